// File: rtl/chord_param_fifo_pkg.sv
// Shared defaults, pointer-width helper and status struct for the CHORD parametrised FIFO.
package chord_fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  // One extra bit beyond the address so full and empty differ at equal addresses.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/chord_param_fifo_if.sv
// Producer/consumer-facing signal bundle of the CHORD parametrised FIFO.
interface chord_param_fifo_if
  import chord_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  localparam int PW = ptr_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [PW-1:0]     level;
  logic              overflow;
  logic              underflow;
  logic              err_clr;
  logic              ovf_sticky;
  logic              udf_sticky;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, empty, full, almost_full, almost_empty, level,
           overflow, underflow, ovf_sticky, udf_sticky
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, empty, full, almost_full, almost_empty, level,
           overflow, underflow, ovf_sticky, udf_sticky
  );

endinterface

// File: rtl/chord_param_fifo_ptr.sv
// Wrapping FIFO pointer: increments by one on inc, rolls over modulo 2^PW.
module chord_fifo_ptr #(
  parameter int PW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/chord_param_fifo.sv
// First-word-fall-through FIFO with level/flags and overflow/underflow strobes.
// Optional sticky error flags are built when CHORD_FIFO_STICKY_ERR_EN is defined.
module chord_param_fifo
  import chord_fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input logic               clk,
  input logic               reset,
  chord_param_fifo_if.slave fifo
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_LEVEL);

  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [PW-1:0]     level;
  fifo_status_t      status;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              overflow_q;
  logic              overflow_d;
  logic              underflow_q;
  logic              underflow_d;

  always_comb begin
    level               = wp - rp;
    status.empty        = (level == '0);
    status.full         = (level == FULL_LVL);
    status.almost_full  = (level >= AF_LVL);
    status.almost_empty = (level <= AE_LVL);
  end

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  always_comb begin
    rd_acc      = fifo.rd_en && !status.empty;
    wr_acc      = fifo.wr_en && (!status.full || rd_acc);
    overflow_d  = fifo.wr_en && !wr_acc;
    underflow_d = fifo.rd_en && status.empty;
  end

  chord_fifo_ptr #(.PW(PW)) u_wp (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wp)
  );

  chord_fifo_ptr #(.PW(PW)) u_rp (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rp)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wp[AW-1:0]] = fifo.wr_data;
  end

  // Storage is cleared on reset so the fall-through output reads zero afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef CHORD_FIFO_STICKY_ERR_EN
  logic ovf_sticky_q;
  logic ovf_sticky_d;
  logic udf_sticky_q;
  logic udf_sticky_d;

  // A new event in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_sticky_d = overflow_d  || (ovf_sticky_q && !fifo.err_clr);
    udf_sticky_d = underflow_d || (udf_sticky_q && !fifo.err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  assign fifo.ovf_sticky = ovf_sticky_q;
  assign fifo.udf_sticky = udf_sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr  = fifo.err_clr;
  assign fifo.ovf_sticky = 1'b0;
  assign fifo.udf_sticky = 1'b0;
`endif

  assign fifo.rd_data      = mem_q[rp[AW-1:0]];
  assign fifo.empty        = status.empty;
  assign fifo.full         = status.full;
  assign fifo.almost_full  = status.almost_full;
  assign fifo.almost_empty = status.almost_empty;
  assign fifo.level        = level;
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_chord_param_fifo.sv
// Bench for chord_param_fifo: directed scenarios plus random traffic against a queue model.
module tb_chord_param_fifo;
  import chord_fifo_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  chord_param_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo ();

  chord_param_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (fifo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] q [$];
  bit m_ovf_st = 1'b0;
  bit m_udf_st = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string ctx);
    int n;
    n = q.size();
    check({ctx, ":level"}, 64'(fifo.level), 64'(n));
    check({ctx, ":empty"}, 64'(fifo.empty), 64'(n == 0));
    check({ctx, ":full"}, 64'(fifo.full), 64'(n == DEPTH));
    check({ctx, ":almost_full"}, 64'(fifo.almost_full), 64'(n >= AF));
    check({ctx, ":almost_empty"}, 64'(fifo.almost_empty), 64'(n <= AE));
    if (n > 0) check({ctx, ":rd_data"}, 64'(fifo.rd_data), 64'(q[0]));
`ifdef CHORD_FIFO_STICKY_ERR_EN
    check({ctx, ":ovf_sticky"}, 64'(fifo.ovf_sticky), 64'(m_ovf_st));
    check({ctx, ":udf_sticky"}, 64'(fifo.udf_sticky), 64'(m_udf_st));
`else
    check({ctx, ":ovf_sticky"}, 64'(fifo.ovf_sticky), 64'(0));
    check({ctx, ":udf_sticky"}, 64'(fifo.udf_sticky), 64'(0));
`endif
  endtask

  // One clock: drive, let the edge pass, then advance the model and compare.
  task automatic step(input string ctx, input bit we, input logic [DATA_W-1:0] wd,
                      input bit re, input bit clr);
    bit racc, wacc, e_ovf, e_udf;
    fifo.wr_en   = we;
    fifo.wr_data = wd;
    fifo.rd_en   = re;
    fifo.err_clr = clr;
    racc  = re && (q.size() > 0);
    wacc  = we && ((q.size() < DEPTH) || racc);
    e_ovf = we && !wacc;
    e_udf = re && (q.size() == 0);
    @(posedge clk);
    #1;
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(wd);
    m_ovf_st = e_ovf || (m_ovf_st && !clr);
    m_udf_st = e_udf || (m_udf_st && !clr);
    check({ctx, ":overflow"}, 64'(fifo.overflow), 64'(e_ovf));
    check({ctx, ":underflow"}, 64'(fifo.underflow), 64'(e_udf));
    check_state(ctx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    fifo.wr_en   = 1'b0;
    fifo.wr_data = '0;
    fifo.rd_en   = 1'b0;
    fifo.err_clr = 1'b0;

    #2 reset = 1'b0;
    #2;
    check("reset:rd_data", 64'(fifo.rd_data), 64'(0));
    check_state("reset");
    @(posedge clk);
    @(posedge clk);
    #4 reset = 1'b1;
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
    step("ovf", 1'b1, 32'hDEAD, 1'b0, 1'b0);
    step("ovf_end", 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("udf", 1'b0, '0, 1'b1, 1'b0);
    step("udf_end", 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 32'h200 + DATA_W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("full_rw", 1'b1, 32'h100 + DATA_W'(i), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);

    step("wr_rd_empty", 1'b1, 32'hA5, 1'b1, 1'b0);
    check("wr_rd_empty:a5", 64'(fifo.rd_data), 64'h A5);
    step("err_clr", 1'b0, '0, 1'b0, 1'b1);
    step("err_clr_udf", 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) step("fill8", 1'b1, 32'h300 + DATA_W'(i), 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_rst:level", 64'(fifo.level), 64'(0));
    check("async_rst:empty", 64'(fifo.empty), 64'(1));
    check("async_rst:rd_data", 64'(fifo.rd_data), 64'(0));
    q.delete();
    m_ovf_st = 1'b0;
    m_udf_st = 1'b0;
    @(posedge clk);
    #4 reset = 1'b1;
    step("post_rst", 1'b1, 32'h77, 1'b0, 1'b0);
    check("post_rst:77", 64'(fifo.rd_data), 64'h77);

    for (int blk = 0; blk < 6; blk++) begin
      int pw, pr;
      pw = 20 + blk * 12;
      pr = 80 - blk * 12;
      for (int i = 0; i < 500; i++) begin
        step("rand", ($urandom_range(0, 99) < pw), DATA_W'($urandom),
             ($urandom_range(0, 99) < pr), ($urandom_range(0, 15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
